// File: rtl/unaligned_wr_mem_if.sv
// Store/readback bus for unaligned_wr_mem: one byte-addressed store channel,
// one aligned word readback port and completion status.
interface unaligned_wr_mem_if #(
    parameter int AW = 9
);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW-3:0] rd_addr;
    logic [31:0]   rd_data;
    logic          done;
    logic          err;
    logic [15:0]   store_cnt;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_addr,
        input  wr_ready, rd_data, done, err, store_cnt
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_addr,
        output wr_ready, rd_data, done, err, store_cnt
    );
endinterface

// File: rtl/unaligned_wr_mem.sv
// Word-organised memory that accepts 32-bit big-endian stores at any byte
// alignment, splitting an unaligned store into a low-word and a high-word write.
module unaligned_wr_mem #(
    parameter int DEPTH = 128,
    parameter int AW    = 9
) (
    input  logic              clk,
    input  logic              rst,
    unaligned_wr_mem_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR_LO = 2'd1;
    localparam logic [1:0] S_WR_HI = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_data;
    logic [15:0]   r_cnt;
    logic [31:0]   r_mem [DEPTH];

    logic [AW-3:0] w_k;
    logic [AW-3:0] w_k_nxt;
    logic [1:0]    w_off;
    logic [4:0]    w_shift;
    logic [5:0]    w_hi_shift;
    logic [31:0]   w_lo_mask;
    logic [31:0]   w_lo_word;
    logic [31:0]   w_hi_word;
    logic          w_overrun;

    assign w_k        = r_addr[AW-1:2];
    assign w_k_nxt    = w_k + (AW-2)'(1);
    assign w_off      = r_addr[1:0];
    assign w_shift    = {w_off, 3'b000};
    assign w_hi_shift = 6'd32 - {1'b0, w_shift};

    // w_lo_mask covers the bytes of word k at and after the store address;
    // its complement is exactly the bytes of word k+1 the store spills into.
    assign w_lo_mask = 32'hFFFF_FFFF >> w_shift;
    assign w_lo_word = (r_mem[w_k] & ~w_lo_mask) | (r_data >> w_shift);
    assign w_hi_word = (r_mem[w_k_nxt] & w_lo_mask) | (r_data << w_hi_shift);

    // Spill past the last word is dropped rather than wrapped to word 0.
    assign w_overrun = (w_off != 2'd0) && (w_k == (AW-2)'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            // NOTE: the array is cleared by reset, which forces it into
            // flops; a RAM macro could not be wiped in a single edge.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.wr_valid) begin
                        r_addr  <= bus.wr_addr;
                        r_data  <= bus.wr_data;
                        r_state <= S_WR_LO;
                    end
                end
                S_WR_LO: begin
                    r_mem[w_k] <= w_lo_word;
                    r_state    <= (w_off == 2'd0) ? S_FIN : S_WR_HI;
                end
                S_WR_HI: begin
                    if (!w_overrun) begin
                        r_mem[w_k_nxt] <= w_hi_word;
                    end
                    r_state <= S_FIN;
                end
                default: begin
                    r_cnt   <= r_cnt + 16'd1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ready  = (r_state == S_IDLE);
    assign bus.done      = (r_state == S_FIN);
    assign bus.err       = (r_state == S_FIN) && w_overrun;
    assign bus.store_cnt = r_cnt;
    assign bus.rd_data   = r_mem[bus.rd_addr];
endmodule

// File: tb/tb_unaligned_wr_mem.sv
// Randomised bench for unaligned_wr_mem: a byte-array model of memory is
// updated per store and compared against aligned word readback.
module tb_unaligned_wr_mem;
    localparam int DEPTH  = 128;
    localparam int AW     = 9;
    localparam int NBYTES = DEPTH * 4;

    logic clk;
    logic rst;

    unaligned_wr_mem_if #(.AW(AW)) bus ();

    unaligned_wr_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  m_bytes [NBYTES];
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_word(input int w);
        return {m_bytes[4*w], m_bytes[4*w+1], m_bytes[4*w+2], m_bytes[4*w+3]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NBYTES; i++) m_bytes[i] = 8'h00;
        m_cnt = 16'd0;
    endtask

    // Big-endian byte placement; bytes past the end of memory are lost.
    task automatic model_store(input int a, input logic [31:0] d, output logic exp_err);
        for (int i = 0; i < 4; i++) begin
            if (a + i < NBYTES) m_bytes[a+i] = d[31-8*i -: 8];
        end
        exp_err = (a + 3 >= NBYTES);
        m_cnt   = m_cnt + 16'd1;
    endtask

    task automatic read_word(input int w, output logic [31:0] v);
        bus.rd_addr = (AW-2)'(w);
        #1;
        v = bus.rd_data;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] v;
        for (int w = 0; w < DEPTH; w++) begin
            read_word(w, v);
            check(tag, v, exp_word(w));
        end
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the FIN exit edge.
    task automatic do_store(input int a, input logic [31:0] d);
        int       lat;
        int       guard;
        logic     exp_err;
        logic [31:0] r;
        guard = 0;
        while (!bus.wr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.wr_ready) check("ready_timeout", 32'(bus.wr_ready), 32'd1);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(a);
        bus.wr_data  = d;
        @(posedge clk);
        #1;
        model_store(a, d, exp_err);
        r = $urandom;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = r[AW-1:0];
        bus.wr_data  = $urandom;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
        end
        check("latency", 32'(lat), (a % 4 == 0) ? 32'd2 : 32'd3);
        check("err", 32'(bus.err), 32'(exp_err));
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("store_cnt", 32'(bus.store_cnt), 32'(m_cnt));
        check("ready_after_fin", 32'(bus.wr_ready), 32'd1);
    endtask

    task automatic back_to_back();
        int   hs = 0;
        int   dones = 0;
        int   viol = 0;
        logic prev_ready = 1'b0;
        logic want_ready = 1'b0;
        logic hs_now;
        logic e;
        int   a;
        logic [31:0] d;
        a = $urandom_range(0, NBYTES - 8);
        d = $urandom;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(a);
        bus.wr_data  = d;
        for (int cyc = 0; cyc < 40 && (hs < 3 || dones < 3); cyc++) begin
            hs_now = 1'b0;
            if (bus.done) dones++;
            if (want_ready && !bus.wr_ready) viol++;
            want_ready = bus.done;
            if (hs > 0 && prev_ready && bus.wr_ready) viol++;
            prev_ready = bus.wr_ready;
            if (bus.wr_ready && bus.wr_valid) begin
                model_store(a, d, e);
                hs++;
                hs_now = 1'b1;
            end
            @(posedge clk);
            #1;
            if (hs_now) begin
                if (hs < 3) begin
                    a = $urandom_range(0, NBYTES - 8);
                    d = $urandom;
                    bus.wr_addr = AW'(a);
                    bus.wr_data = d;
                end else begin
                    bus.wr_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("b2b_handshakes", 32'(hs), 32'd3);
        check("b2b_done_pulses", 32'(dones), 32'd3);
        check("b2b_ready_pattern", 32'(viol), 32'd0);
        check("b2b_store_cnt", 32'(bus.store_cnt), 32'(m_cnt));
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] r;
        int          seen_done;

        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_addr  = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.wr_ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_cnt", 32'(bus.store_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_all("rst_mem");

        // Aligned store
        do_store(32'h008, 32'hDEAD_BEEF);
        read_word(2, v); check("aligned_w2", v, 32'hDEAD_BEEF);
        read_word(3, v); check("aligned_w3", v, 32'h0000_0000);
        check("aligned_cnt", 32'(bus.store_cnt), 32'd1);
        @(negedge clk);

        // Offset 1 across preset words
        do_store(32'h010, 32'hAABB_CCDD);
        do_store(32'h014, 32'h1122_3344);
        do_store(32'h011, 32'h0102_0304);
        read_word(4, v); check("off1_w4", v, 32'hAA01_0203);
        read_word(5, v); check("off1_w5", v, 32'h0422_3344);
        @(negedge clk);

        // Offset 3
        do_store(32'h000, 32'hFFFF_FFFF);
        do_store(32'h003, 32'hCAFE_BABE);
        read_word(0, v); check("off3_w0", v, 32'hFFFF_FFCA);
        read_word(1, v); check("off3_w1", v, 32'hFEBA_BE00);
        @(negedge clk);

        // Overrun at the top word
        do_store(32'h1FE, 32'h1234_5678);
        read_word(127, v); check("ovr_w127", v, 32'h0000_1234);
        read_word(0, v);   check("ovr_w0", v, 32'hFFFF_FFCA);
        @(negedge clk);

        // Random stores over the whole address range, including the top edge
        for (int i = 0; i < 40; i++) begin
            do_store($urandom_range(0, NBYTES - 1), $urandom);
        end
        check_all("rand_mem");

        back_to_back();
        check_all("b2b_mem");

        // Reset in WR_HI with wr_valid held high
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(32'h021);
        bus.wr_data  = $urandom;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst          = 1'b1;
        bus.wr_valid = 1'b1;
        r            = $urandom;
        bus.wr_addr  = r[AW-1:0];
        #1;
        check("midrst_ready", 32'(bus.wr_ready), 32'd1);
        check("midrst_done", 32'(bus.done), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        bus.wr_valid = 1'b0;
        rst          = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        check("midrst_no_done", 32'(seen_done), 32'd0);
        check("midrst_cnt", 32'(bus.store_cnt), 32'd0);
        check("midrst_ready_after", 32'(bus.wr_ready), 32'd1);
        check_all("midrst_mem");

        do_store(32'h1FF, 32'hA5A5_5A5A);
        do_store(32'h022, 32'h0BAD_F00D);
        check_all("final_mem");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/unaligned_wr_mem.md
UNALIGNED_WR_MEM -- requirements
Module: unaligned_wr_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning number of 32-bit words in the array.
REQ-002 SHALL have parameter AW, default 9, meaning byte-address width (DEPTH*4 bytes addressable).
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_valid  input  1  store request present.
REQ-006 SHALL have port wr_ready  output  1  block can accept a store.
REQ-007 SHALL have port wr_addr  input  AW  byte address of store, any alignment.
REQ-008 SHALL have port wr_data  input  32  store data, big-endian (wr_data[31:24] lands at wr_addr).
REQ-009 SHALL have port rd_addr  input  AW-2  word index for aligned readback.
REQ-010 SHALL have port rd_data  output  32  combinational word at rd_addr.
REQ-011 SHALL have port done  output  1  one-cycle pulse, store complete.
REQ-012 SHALL have port err  output  1  one-cycle pulse with done, store overran last word.
REQ-013 SHALL have port store_cnt  output  16  count of completed stores.

Function
REQ-014 SHALL implement FSM states IDLE, WR_LO, WR_HI, FIN.
REQ-015 SHALL drive wr_ready=1 only in IDLE; handshake occurs on rising edge with wr_valid&&wr_ready.
REQ-016 SHALL capture wr_addr and wr_data at the handshake edge and move IDLE->WR_LO; later input changes are ignored.
REQ-017 SHALL define k=addr>>2 and o=addr[1:0] from captured address; byte at address a is word[a>>2] bits [31-8*(a%4) -: 8].
REQ-018 SHALL in WR_LO, at the next edge, write word k bits [31-8o:0] <= data[31:8o], preserving word k bits [31:32-8o].
REQ-019 SHALL transition WR_LO->FIN when o==0, else WR_LO->WR_HI.
REQ-020 SHALL in WR_HI, at the next edge, write word k+1 bits [31:32-8o] <= data[8o-1:0], preserving word k+1 bits [31-8o:0]; then go to FIN.
REQ-021 SHALL, when o!=0 and k==DEPTH-1, suppress the WR_HI write (no wrap to word 0), and assert err with done in FIN.
REQ-022 SHALL in FIN assert done=1 for exactly one cycle, increment store_cnt by 1 (wrapping 0xFFFF->0x0000) at the FIN exit edge, and return to IDLE.
REQ-023 SHALL give handshake-to-done latency of 2 cycles for aligned (o==0) stores and 3 cycles for unaligned stores.
REQ-024 SHALL make rd_data reflect each memory write in the cycle following the write edge; same-cycle rd_addr==written word returns the old value.
REQ-025 SHALL keep done and err at 0 in all states other than FIN.
REQ-026 SHALL accept back-to-back stores: wr_ready reasserts the cycle after FIN.

Reset
REQ-027 SHALL on rst force state IDLE, wr_ready=1, done=0, err=0, store_cnt=0, and clear all DEPTH words to 0x00000000.
REQ-028 SHALL on rst during WR_LO/WR_HI/FIN abandon the store: no further writes, no done pulse, store_cnt stays 0.
REQ-029 SHALL ignore wr_valid while rst is high.

Verification
REQ-030 SHALL test aligned: wr_addr=0x008, wr_data=0xDEADBEEF -> done 2 cycles after handshake, word 2=0xDEADBEEF, word 3=0, store_cnt=1.
REQ-031 SHALL test offset 1: words 4,5 preset 0xAABBCCDD, 0x11223344; store 0x011 data 0x01020304 -> word 4=0xAA010203, word 5=0x04223344, done at 3 cycles.
REQ-032 SHALL test offset 3: word 0 preset 0xFFFFFFFF; store 0x003 data 0xCAFEBABE -> word 0=0xFFFFFFCA, word 1=0xFEBABE00.
REQ-033 SHALL test overrun: store 0x1FE data 0x12345678 -> word 127 low half=0x1234, word 0 unchanged, err=1 with done.
REQ-034 SHALL test reset mid-store: assert rst in WR_HI -> all words 0, store_cnt=0, no done, wr_ready=1 after release.
REQ-035 SHALL test back-to-back: wr_valid held high for 3 stores -> three done pulses, wr_ready low between handshakes, store_cnt=3.
